// File: rtl/hdec_decim_out.sv
// rtl/hdec_decim_out.sv - halfband FIR output stage: warm-up discard, decimate by 2, round/saturate, output FIFO
module hdec_decim_out #(
    parameter int IN_W   = 20,
    parameter int OUT_W  = 10,
    parameter int SHIFT  = 9,
    parameter int WARMUP = 21,
    parameter int PHASE  = 0,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      in_valid,
    input  logic signed [IN_W-1:0]    din,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   dout,
    output logic                      overflow,
    output logic                      sat_flag,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WARMUP + 1);
    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MINV = ~MAXV;

    logic [CW-1:0]            warm_cnt_q, warm_cnt_d;
    logic                     phase_q, phase_d;
    logic                     s1_valid_q;
    logic signed [OUT_W-1:0]  s1_data_q, s1_data_d;
    logic signed [OUT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic signed [OUT_W-1:0]  dout_q, dout_d;
    logic                     overflow_q, sat_q;

    logic                     warm_done, keep, clip_hi, clip_lo;
    logic                     pop, full, push, drop;
    logic signed [IN_W:0]     t, r;

    assign warm_done = (warm_cnt_q == CW'(WARMUP));
    assign keep      = in_valid && warm_done && (phase_q == PHASE[0]);

    always_comb begin
        t = {din[IN_W-1], din} + RND;
        r = t >>> SHIFT;
        clip_hi = (r > MAXV);
        clip_lo = (r < MINV);
        s1_data_d = r[OUT_W-1:0];
        if (clip_hi) begin
            s1_data_d = MAXV[OUT_W-1:0];
        end else if (clip_lo) begin
            s1_data_d = MINV[OUT_W-1:0];
        end
    end

    // Phase only starts toggling once the filter pipeline has filled.
    always_comb begin
        warm_cnt_d = warm_cnt_q;
        phase_d    = phase_q;
        if (in_valid) begin
            if (!warm_done) begin
                warm_cnt_d = warm_cnt_q + CW'(1);
            end else begin
                phase_d = ~phase_q;
            end
        end
    end

    always_comb begin
        pop      = (level_q != '0) && out_ready;
        full     = (level_q == LW'(DEPTH));
        push     = s1_valid_q && (!full || pop);
        drop     = s1_valid_q && full && !pop;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        dout_d   = dout_q;
        // The new head is the sample being written when it lands in the slot rd_ptr moves to.
        if (level_d != '0) begin
            dout_d = (push && (wr_ptr_q == rd_ptr_d)) ? s1_data_q : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_cnt_q <= '0;
            phase_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            dout_q     <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else if (clr) begin
            warm_cnt_q <= '0;
            phase_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            dout_q     <= '0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
            phase_q    <= phase_d;
            s1_valid_q <= keep;
            if (keep) begin
                s1_data_q <= s1_data_d;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            dout_q     <= dout_d;
            overflow_q <= overflow_q | drop;
            sat_q      <= sat_q | (keep && (clip_hi || clip_lo));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    assign out_valid  = (level_q != '0);
    assign dout       = dout_q;
    assign overflow   = overflow_q;
    assign sat_flag   = sat_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_hdec_decim_out.sv
// tb/tb_hdec_decim_out.sv - self-checking bench for hdec_decim_out
module tb_hdec_decim_out;
    localparam int IN_W  = 20;
    localparam int OUT_W = 10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic resetn1 = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic rdy1 = 1'b1;
    logic signed [IN_W-1:0] din = '0;
    logic out_valid0, out_valid1, ov0, ov1, sat0, sat1;
    logic signed [OUT_W-1:0] dout0, dout1;
    logic [2:0] lvl0, lvl1;

    int checks = 0;
    int errors = 0;
    int q0[$];
    int q1[$];

    typedef struct {
        logic v;
        int   d;
        logic k0;
        logic k1;
        int   e;
    } rec_t;
    rec_t tbl[34];

    always #5 clk = ~clk;

    hdec_decim_out #(.PHASE(0)) dut0 (
        .clk(clk), .reset(resetn), .clr(clr), .in_valid(in_valid), .din(din),
        .out_ready(out_ready), .out_valid(out_valid0), .dout(dout0),
        .overflow(ov0), .sat_flag(sat0), .fifo_level(lvl0)
    );

    hdec_decim_out #(.PHASE(1)) dut1 (
        .clk(clk), .reset(resetn1), .clr(clr), .in_valid(in_valid), .din(din),
        .out_ready(rdy1), .out_valid(out_valid1), .dout(dout1),
        .overflow(ov1), .sat_flag(sat1), .fifo_level(lvl1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input int d, input logic k0, input logic k1, input int e);
        in_valid = v;
        din = IN_W'(d);
        if (k0) q0.push_back(e);
        if (k1) q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(tbl[i].v, tbl[i].d, tbl[i].k0, tbl[i].k1, tbl[i].e);
    endtask

    task automatic ramp();
        out_ready = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            apply(1'b1, n * 512, (n >= 21) && (((n - 21) % 2) == 0), 1'b0, n);
            if (n == 21) chk("lat_not_yet_valid", out_valid0, 0);
            if (n == 22) begin
                chk("lat_valid", out_valid0, 1);
                chk("lat_first_dout", int'(dout0), 21);
            end
        end
        idle(3);
        chk("ramp_all_seen", q0.size(), 0);
    endtask

    // Scoreboard: each handshake pops the oldest expected sample.
    always @(negedge clk) begin
        if (resetn && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out0: got dout=%0d expected no output", dout0);
            end else begin
                chk("dout0", int'(dout0), q0.pop_front());
            end
        end
        if (resetn1 && out_valid1 && rdy1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out1: got dout=%0d expected no output", dout1);
            end else begin
                chk("dout1", int'(dout1), q1.pop_front());
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b1, 256,     1'b1, 1'b0, 1};
        tbl[1]  = '{1'b1, 400000,  1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 255,     1'b1, 1'b0, 0};
        tbl[3]  = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, -256,    1'b1, 1'b0, 0};
        tbl[5]  = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1, -257,    1'b1, 1'b0, -1};
        tbl[7]  = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[8]  = '{1'b1, 767,     1'b1, 1'b0, 1};
        tbl[9]  = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[10] = '{1'b1, 300000,  1'b1, 1'b0, 511};
        tbl[11] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[12] = '{1'b1, -524288, 1'b1, 1'b0, -512};
        tbl[13] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[14] = '{1'b1, 512,     1'b1, 1'b0, 1};
        tbl[15] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[16] = '{1'b1, 1024,    1'b1, 1'b0, 2};
        tbl[17] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[18] = '{1'b1, 1536,    1'b1, 1'b0, 3};
        tbl[19] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[20] = '{1'b1, 2048,    1'b1, 1'b0, 4};
        tbl[21] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[22] = '{1'b1, 2560,    1'b0, 1'b0, 5};
        tbl[23] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[24] = '{1'b1, 3072,    1'b0, 1'b0, 6};
        tbl[25] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[26] = '{1'b1, 2560,    1'b1, 1'b0, 5};
        tbl[27] = '{1'b1, 0,       1'b0, 1'b0, 0};
        tbl[28] = '{1'b1, 2560,    1'b1, 1'b0, 5};
        tbl[29] = '{1'b0, 999,     1'b0, 1'b0, 0};
        tbl[30] = '{1'b0, 999,     1'b0, 1'b0, 0};
        tbl[31] = '{1'b1, 3072,    1'b0, 1'b1, 6};
        tbl[32] = '{1'b0, 999,     1'b0, 1'b0, 0};
        tbl[33] = '{1'b1, 3584,    1'b1, 1'b0, 7};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_dout", int'(dout0), 0);
        chk("rst_level", lvl0, 0);
        chk("rst_overflow", ov0, 0);
        chk("rst_sat", sat0, 0);
        resetn = 1'b1;

        ramp();

        // Full FIFO with simultaneous pop and push
        out_ready = 1'b0;
        run(14, 21);
        chk("pp_full_level", lvl0, 4);
        run(26, 26);
        out_ready = 1'b1;
        run(27, 27);
        out_ready = 1'b0;
        chk("pp_level_kept", lvl0, 4);
        chk("pp_no_overflow", ov0, 0);
        chk("pp_one_popped", q0.size(), 4);
        out_ready = 1'b1;
        idle(4);
        chk("pp_drained", lvl0, 0);

        // Backpressure and overflow
        out_ready = 1'b0;
        run(14, 25);
        idle(2);
        chk("ov_level", lvl0, 4);
        chk("ov_flag", ov0, 1);
        chk("ov_head", int'(dout0), 1);
        out_ready = 1'b1;
        idle(4);
        chk("ov_drain_level", lvl0, 0);
        chk("ov_drain_valid", out_valid0, 0);
        chk("ov_dout_hold", int'(dout0), 4);
        chk("ov_sticky", ov0, 1);
        chk("ov_queue_empty", q0.size(), 0);

        // Rounding then saturation
        run(0, 9);
        idle(3);
        chk("round_no_sat", sat0, 0);
        run(10, 13);
        idle(3);
        chk("sat_set", sat0, 1);
        idle(5);
        chk("sat_sticky", sat0, 1);
        chk("sat_queue_empty", q0.size(), 0);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        run(14, 19);
        idle(2);
        chk("arst_pre_level", lvl0, 3);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", out_valid0, 0);
        chk("arst_level", lvl0, 0);
        chk("arst_overflow", ov0, 0);
        chk("arst_sat", sat0, 0);
        chk("arst_dout", int'(dout0), 0);
        q0.delete();
        #3;
        resetn = 1'b1;
        ramp();

        // Synchronous clear mid-operation
        out_ready = 1'b0;
        run(14, 25);
        run(10, 11);
        idle(2);
        chk("clr_pre_level", lvl0, 4);
        chk("clr_pre_ov", ov0, 1);
        chk("clr_pre_sat", sat0, 1);
        clr = 1'b1;
        #1;
        chk("clr_waits_edge", lvl0, 4);
        apply(1'b1, 512, 1'b0, 1'b0, 0);
        clr = 1'b0;
        chk("clr_level", lvl0, 0);
        chk("clr_valid", out_valid0, 0);
        chk("clr_overflow", ov0, 0);
        chk("clr_sat", sat0, 0);
        q0.delete();
        ramp();

        // in_valid gaps, both phases
        resetn = 1'b0;
        resetn1 = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        resetn1 = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) apply(1'b1, 0, 1'b0, 1'b0, 0);
        run(28, 33);
        idle(3);
        chk("gap_phase0_done", q0.size(), 0);
        chk("gap_phase1_done", q1.size(), 0);
        resetn1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
